issue_buffer: RTL and testbench

Parametrised instruction-issue stage for the Tomasulo core. Buffers decoded instructions in a DEPTH-entry FIFO, reads source operands (value or tag) from the register bank, keeps snooping the CDB so waiting operands are filled in, issues to a reservation station over a valid/ready handshake, and writes the destination rename (rd → RS tag) back to the bank. It sits between decode and the reservation stations, and replaces the single-instruction, pulse-driven issue stage.

---
 rtl/issue_buffer.sv | 208 ++++++++++++++++++++
 tb/tb_issue_buffer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_buffer.sv
// issue_buffer: decode-side FIFO feeding a reservation station. Each head entry
// is read from the register bank, kept current by snooping the CDB while it
// waits, issued over a valid/ready handshake, then its destination is renamed.
module issue_buffer #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int REG_W  = 5,
  parameter int OP_W   = 5,
  parameter int ICC_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_operator_type,
  input  logic [REG_W-1:0]  in_reg_1,
  input  logic [REG_W-1:0]  in_reg_2,
  input  logic [REG_W-1:0]  in_reg_3,
  input  logic              in_flush,
  output logic              out_rd_en,
  output logic [REG_W-1:0]  out_reg_1,
  output logic [REG_W-1:0]  out_reg_2,
  input  logic [DATA_W-1:0] in_val_1,
  input  logic [DATA_W-1:0] in_val_2,
  input  logic [TAG_W-1:0]  in_tag_1,
  input  logic [TAG_W-1:0]  in_tag_2,
  input  logic [ICC_W-1:0]  in_ICC_flags,
  input  logic              in_CDB_broadcast,
  input  logic [TAG_W-1:0]  in_CDB_tag,
  input  logic [DATA_W-1:0] in_CDB_val,
  output logic              out_rs_valid,
  input  logic              in_rs_ready,
  input  logic [TAG_W-1:0]  in_rs_tag,
  output logic [OP_W-1:0]   out_operator_type,
  output logic [DATA_W-1:0] out_val_1,
  output logic [DATA_W-1:0] out_val_2,
  output logic [TAG_W-1:0]  out_tag_1,
  output logic [TAG_W-1:0]  out_tag_2,
  output logic [ICC_W-1:0]  out_ICC_flags,
  output logic              out_bank_enable,
  output logic [REG_W-1:0]  out_bank_reg,
  output logic [TAG_W-1:0]  out_bank_tag
);

  localparam logic [TAG_W-1:0] INVALID_TAG = '1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, READ, CAPT, ISSUE, RENAME} state_t;
  state_t state;

  logic [OP_W-1:0]  fifo_op [DEPTH];
  logic [REG_W-1:0] fifo_r1 [DEPTH];
  logic [REG_W-1:0] fifo_r2 [DEPTH];
  logic [REG_W-1:0] fifo_rd [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
  logic [CW-1:0] count, count_next;
  logic          push, pop;
  logic [REG_W-1:0] head_rd;

  // An operand waiting on a tag takes the broadcast value when the tags match;
  // a ready operand (INVALID_TAG) is never overwritten.
  function automatic logic cdb_hit(input logic bcast, input logic [TAG_W-1:0] tag,
                                   input logic [TAG_W-1:0] cdb_tag);
    return bcast && (tag == cdb_tag) && (tag != INVALID_TAG);
  endfunction

  assign push       = in_valid & in_ready & ~in_flush;
  assign pop        = (state == ISSUE) & out_rs_valid & in_rs_ready & ~in_flush;
  assign count_next = count + CW'(push) - CW'(pop);
  assign rd_ptr_inc = rd_ptr + PW'(1);
  assign head_rd    = fifo_rd[rd_ptr];

  // FIFO storage: payload only, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr] <= in_operator_type;
      fifo_r1[wr_ptr] <= in_reg_1;
      fifo_r2[wr_ptr] <= in_reg_2;
      fifo_rd[wr_ptr] <= in_reg_3;
    end
  end

  // FIFO pointers, occupancy and registered push-ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else if (in_flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      count    <= count_next;
      in_ready <= (count_next < FULL);
    end
  end

  // Issue FSM: read, capture, issue with CDB snooping, rename; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      out_rd_en         <= 1'b0;
      out_rs_valid      <= 1'b0;
      out_bank_enable   <= 1'b0;
      out_reg_1         <= '0;
      out_reg_2         <= '0;
      out_operator_type <= '0;
      out_val_1         <= '0;
      out_val_2         <= '0;
      out_tag_1         <= INVALID_TAG;
      out_tag_2         <= INVALID_TAG;
      out_ICC_flags     <= '0;
      out_bank_reg      <= '0;
      out_bank_tag      <= '0;
    end else if (in_flush) begin
      state           <= IDLE;
      out_rd_en       <= 1'b0;
      out_rs_valid    <= 1'b0;
      out_bank_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state     <= READ;
            out_rd_en <= 1'b1;
            out_reg_1 <= fifo_r1[rd_ptr];
            out_reg_2 <= fifo_r2[rd_ptr];
          end
        end
        READ: begin
          out_rd_en <= 1'b0;
          state     <= CAPT;
        end
        CAPT: begin
          if (cdb_hit(in_CDB_broadcast, in_tag_1, in_CDB_tag)) begin
            out_val_1 <= in_CDB_val;
            out_tag_1 <= INVALID_TAG;
          end else begin
            out_val_1 <= in_val_1;
            out_tag_1 <= in_tag_1;
          end
          if (cdb_hit(in_CDB_broadcast, in_tag_2, in_CDB_tag)) begin
            out_val_2 <= in_CDB_val;
            out_tag_2 <= INVALID_TAG;
          end else begin
            out_val_2 <= in_val_2;
            out_tag_2 <= in_tag_2;
          end
          out_ICC_flags     <= in_ICC_flags;
          out_operator_type <= fifo_op[rd_ptr];
          out_rs_valid      <= 1'b1;
          state             <= ISSUE;
        end
        ISSUE: begin
          if (pop) begin
            out_rs_valid <= 1'b0;
            out_bank_reg <= head_rd;
            out_bank_tag <= in_rs_tag;
            if (head_rd != '0) begin
              out_bank_enable <= 1'b1;
              state           <= RENAME;
            end else if (count > CW'(1)) begin
              // entries already queued behind the head; a same-cycle push is
              // picked up later through IDLE
              out_rd_en <= 1'b1;
              out_reg_1 <= fifo_r1[rd_ptr_inc];
              out_reg_2 <= fifo_r2[rd_ptr_inc];
              state     <= READ;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (cdb_hit(in_CDB_broadcast, out_tag_1, in_CDB_tag)) begin
              out_val_1 <= in_CDB_val;
              out_tag_1 <= INVALID_TAG;
            end
            if (cdb_hit(in_CDB_broadcast, out_tag_2, in_CDB_tag)) begin
              out_val_2 <= in_CDB_val;
              out_tag_2 <= INVALID_TAG;
            end
          end
        end
        RENAME: begin
          out_bank_enable <= 1'b0;
          if (count != '0) begin
            out_rd_en <= 1'b1;
            out_reg_1 <= fifo_r1[rd_ptr];
            out_reg_2 <= fifo_r2[rd_ptr];
            state     <= READ;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_buffer.sv
// tb_issue_buffer: directed vectors for issue_buffer with a 1-cycle register bank model.
module tb_issue_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_operator_type, in_reg_1, in_reg_2, in_reg_3;
  logic        in_flush;
  logic        out_rd_en;
  logic [4:0]  out_reg_1, out_reg_2;
  logic [31:0] in_val_1, in_val_2;
  logic [4:0]  in_tag_1, in_tag_2;
  logic [3:0]  in_ICC_flags;
  logic        in_CDB_broadcast;
  logic [4:0]  in_CDB_tag;
  logic [31:0] in_CDB_val;
  logic        out_rs_valid;
  logic        in_rs_ready;
  logic [4:0]  in_rs_tag;
  logic [4:0]  out_operator_type;
  logic [31:0] out_val_1, out_val_2;
  logic [4:0]  out_tag_1, out_tag_2;
  logic [3:0]  out_ICC_flags;
  logic        out_bank_enable;
  logic [4:0]  out_bank_reg;
  logic [4:0]  out_bank_tag;

  issue_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_operator_type(in_operator_type), .in_reg_1(in_reg_1), .in_reg_2(in_reg_2),
    .in_reg_3(in_reg_3), .in_flush(in_flush),
    .out_rd_en(out_rd_en), .out_reg_1(out_reg_1), .out_reg_2(out_reg_2),
    .in_val_1(in_val_1), .in_val_2(in_val_2), .in_tag_1(in_tag_1), .in_tag_2(in_tag_2),
    .in_ICC_flags(in_ICC_flags),
    .in_CDB_broadcast(in_CDB_broadcast), .in_CDB_tag(in_CDB_tag), .in_CDB_val(in_CDB_val),
    .out_rs_valid(out_rs_valid), .in_rs_ready(in_rs_ready), .in_rs_tag(in_rs_tag),
    .out_operator_type(out_operator_type), .out_val_1(out_val_1), .out_val_2(out_val_2),
    .out_tag_1(out_tag_1), .out_tag_2(out_tag_2), .out_ICC_flags(out_ICC_flags),
    .out_bank_enable(out_bank_enable), .out_bank_reg(out_bank_reg), .out_bank_tag(out_bank_tag)
  );

  always #5 clk = ~clk;

  // Register bank model: values/tags, 1-cycle read, rename writes, bench config port
  logic [31:0] bank_val [32];
  logic [4:0]  bank_tag [32];
  logic        cfg_we, cfg_init;
  logic [4:0]  cfg_addr, cfg_tag;
  logic [31:0] cfg_val;

  always @(posedge clk) begin
    if (cfg_init) begin
      for (int i = 0; i < 32; i++) begin
        bank_val[i] <= '0;
        bank_tag[i] <= 5'h1F;
      end
    end
    if (cfg_we) begin
      bank_val[cfg_addr] <= cfg_val;
      bank_tag[cfg_addr] <= cfg_tag;
    end
    if (out_bank_enable) bank_tag[out_bank_reg] <= out_bank_tag;
    if (out_rd_en) begin
      in_val_1     <= bank_val[out_reg_1];
      in_val_2     <= bank_val[out_reg_2];
      in_tag_1     <= bank_tag[out_reg_1];
      in_tag_2     <= bank_tag[out_reg_2];
      in_ICC_flags <= out_reg_1[3:0] ^ 4'h5;
    end
  end

  typedef struct packed {
    logic [4:0]  op, r1, r2, rd, rs_tag;
    logic [31:0] v1, v2;
    logic [4:0]  t1, t2;
  } vec_t;

  vec_t tbl  [5];
  vec_t fill [5];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // advance to next negedge; drop in_valid once the DUT has taken the push
  task automatic step();
    logic pushed;
    pushed = in_valid && in_ready && !in_flush;
    @(negedge clk);
    if (pushed) in_valid = 1'b0;
  endtask

  task automatic set_reg(input logic [4:0] a, input logic [31:0] v, input logic [4:0] t);
    cfg_we = 1'b1; cfg_addr = a; cfg_val = v; cfg_tag = t;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic bank_clear();
    cfg_init = 1'b1;
    step();
    cfg_init = 1'b0;
  endtask

  task automatic push_instr(input logic [4:0] op, input logic [4:0] r1,
                            input logic [4:0] r2, input logic [4:0] rd);
    in_operator_type = op; in_reg_1 = r1; in_reg_2 = r2; in_reg_3 = rd;
    in_valid = 1'b1;
    for (int n = 0; n < 60 && in_valid; n++) step();
    if (in_valid) begin
      fail_now("push");
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_rs_valid && lat < 60) begin
      step();
      lat++;
    end
    if (!out_rs_valid) fail_now("issue_wait");
  endtask

  task automatic do_issue(input int id, input vec_t v, input int exp_lat);
    int lat;
    wait_valid(lat);
    if (exp_lat > 0) chk($sformatf("latency#%0d", id), lat, exp_lat);
    chk($sformatf("op#%0d", id), out_operator_type, v.op);
    chk($sformatf("val1#%0d", id), out_val_1, v.v1);
    chk($sformatf("val2#%0d", id), out_val_2, v.v2);
    chk($sformatf("tag1#%0d", id), out_tag_1, v.t1);
    chk($sformatf("tag2#%0d", id), out_tag_2, v.t2);
    chk($sformatf("icc#%0d", id), out_ICC_flags, v.r1[3:0] ^ 4'h5);
    in_rs_ready = 1'b1;
    in_rs_tag   = v.rs_tag;
    step();
    in_rs_ready = 1'b0;
    chk($sformatf("valid_drop#%0d", id), out_rs_valid, 1'b0);
    chk($sformatf("bank_en#%0d", id), out_bank_enable, v.rd != 5'd0);
    if (v.rd != 5'd0) begin
      chk($sformatf("bank_reg#%0d", id), out_bank_reg, v.rd);
      chk($sformatf("bank_tag#%0d", id), out_bank_tag, v.rs_tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int lat;
    tbl[0]  = '{5'd1,  5'd1, 5'd2, 5'd3, 5'd7,  32'd10,     32'd20,     5'h1F, 5'h1F};
    tbl[1]  = '{5'd2,  5'd3, 5'd4, 5'd0, 5'd8,  32'd0,      32'h55,     5'd7,  5'h1F};
    tbl[2]  = '{5'd3,  5'd5, 5'd6, 5'd6, 5'd2,  32'd0,      32'h1234,   5'd9,  5'h1F};
    tbl[3]  = '{5'd4,  5'd6, 5'd1, 5'd1, 5'd3,  32'h1234,   32'd10,     5'd2,  5'h1F};
    tbl[4]  = '{5'd31, 5'd0, 5'd0, 5'd0, 5'd4,  32'd0,      32'd0,      5'h1F, 5'h1F};
    fill[0] = '{5'd6,  5'd1, 5'd2, 5'd3, 5'd7,  32'd10,     32'd20,     5'h1F, 5'h1F};
    fill[1] = '{5'd7,  5'd3, 5'd4, 5'd0, 5'd11, 32'h33,     32'h44,     5'd7,  5'h1F};
    fill[2] = '{5'd8,  5'd4, 5'd1, 5'd4, 5'd12, 32'h44,     32'd10,     5'h1F, 5'h1F};
    fill[3] = '{5'd9,  5'd4, 5'd3, 5'd2, 5'd13, 32'h44,     32'h33,     5'd12, 5'd7};
    fill[4] = '{5'd10, 5'd2, 5'd0, 5'd0, 5'd14, 32'd20,     32'd0,      5'd13, 5'h1F};

    rst_n = 1'b1; in_valid = 1'b0; in_flush = 1'b0;
    in_operator_type = '0; in_reg_1 = '0; in_reg_2 = '0; in_reg_3 = '0;
    in_CDB_broadcast = 1'b0; in_CDB_tag = '0; in_CDB_val = '0;
    in_rs_ready = 1'b0; in_rs_tag = '0;
    cfg_we = 1'b0; cfg_init = 1'b0; cfg_addr = '0; cfg_val = '0; cfg_tag = '0;

    // asynchronous reset state, before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_rs_valid", out_rs_valid, 1'b0);
    chk("rst_rd_en", out_rd_en, 1'b0);
    chk("rst_bank_en", out_bank_enable, 1'b0);
    chk("rst_tag1", out_tag_1, 5'h1F);
    chk("rst_tag2", out_tag_2, 5'h1F);
    chk("rst_val1", out_val_1, 32'd0);
    chk("rst_op", out_operator_type, 5'd0);
    chk("rst_bank_tag", out_bank_tag, 5'd0);
    @(negedge clk);
    bank_clear();
    rst_n = 1'b1;
    step();

    set_reg(5'd1, 32'd10, 5'h1F);
    set_reg(5'd2, 32'd20, 5'h1F);
    set_reg(5'd4, 32'h55, 5'h1F);
    set_reg(5'd5, 32'd0, 5'd9);
    set_reg(5'd6, 32'h1234, 5'h1F);

    // one instruction at a time from IDLE: latency, operands, rename
    for (int i = 0; i < 5; i++) begin
      push_instr(tbl[i].op, tbl[i].r1, tbl[i].r2, tbl[i].rd);
      do_issue(i, tbl[i], 3);
    end

    // waiting operands filled from the CDB while the RS stalls
    set_reg(5'd7, 32'd0, 5'd4);
    set_reg(5'd8, 32'h77, 5'd4);
    push_instr(5'd5, 5'd7, 5'd8, 5'd0);
    wait_valid(lat);
    chk("wait_tag1", out_tag_1, 5'd4);
    chk("wait_tag2", out_tag_2, 5'd4);
    in_CDB_broadcast = 1'b1; in_CDB_tag = 5'd5; in_CDB_val = 32'hBEEF;
    step();
    in_CDB_broadcast = 1'b0;
    chk("unrel_val1", out_val_1, 32'd0);
    chk("unrel_tag1", out_tag_1, 5'd4);
    chk("unrel_val2", out_val_2, 32'h77);
    in_CDB_broadcast = 1'b1; in_CDB_tag = 5'd4; in_CDB_val = 32'hDEAD;
    step();
    in_CDB_broadcast = 1'b0;
    chk("cdb_val1", out_val_1, 32'hDEAD);
    chk("cdb_tag1", out_tag_1, 5'h1F);
    chk("cdb_val2", out_val_2, 32'hDEAD);
    chk("cdb_tag2", out_tag_2, 5'h1F);
    chk("cdb_hold_valid", out_rs_valid, 1'b1);
    in_rs_ready = 1'b1; in_rs_tag = 5'd1;
    step();
    in_rs_ready = 1'b0;
    chk("cdb_accept", out_rs_valid, 1'b0);

    // CDB bypass during the capture cycle
    set_reg(5'd9, 32'd0, 5'd2);
    set_reg(5'd10, 32'h10, 5'h1F);
    push_instr(5'd6, 5'd9, 5'd10, 5'd0);
    step();
    step();
    in_CDB_broadcast = 1'b1; in_CDB_tag = 5'd2; in_CDB_val = 32'd99;
    step();
    in_CDB_broadcast = 1'b0;
    chk("byp_valid", out_rs_valid, 1'b1);
    chk("byp_val1", out_val_1, 32'd99);
    chk("byp_tag1", out_tag_1, 5'h1F);
    chk("byp_val2", out_val_2, 32'h10);
    in_rs_ready = 1'b1; in_rs_tag = 5'd2;
    step();
    in_rs_ready = 1'b0;

    // fill with RS stalled, 5th held, then drain in order across the wrap
    bank_clear();
    set_reg(5'd1, 32'd10, 5'h1F);
    set_reg(5'd2, 32'd20, 5'h1F);
    set_reg(5'd3, 32'h33, 5'h1F);
    set_reg(5'd4, 32'h44, 5'h1F);
    for (int j = 0; j < 4; j++) push_instr(fill[j].op, fill[j].r1, fill[j].r2, fill[j].rd);
    chk("full_ready", in_ready, 1'b0);
    in_operator_type = fill[4].op; in_reg_1 = fill[4].r1;
    in_reg_2 = fill[4].r2; in_reg_3 = fill[4].rd;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("held_ready", in_ready, 1'b0);
    chk("held_valid", out_rs_valid, 1'b1);
    chk("held_op", out_operator_type, fill[0].op);
    for (int j = 0; j < 5; j++) do_issue(10 + j, fill[j], 0);

    // flush while issuing with 3 queued; same-cycle push is dropped
    push_instr(5'd11, 5'd1, 5'd2, 5'd5);
    push_instr(5'd12, 5'd2, 5'd1, 5'd0);
    push_instr(5'd13, 5'd1, 5'd1, 5'd0);
    wait_valid(lat);
    chk("fl_op", out_operator_type, 5'd11);
    in_flush = 1'b1;
    in_valid = 1'b1; in_operator_type = 5'd14;
    step();
    in_flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_rs_valid, 1'b0);
    chk("fl_ready", in_ready, 1'b1);
    chk("fl_bank_en", out_bank_enable, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("fl_idle_rd", out_rd_en, 1'b0);
      chk("fl_idle_bank", out_bank_enable, 1'b0);
    end
    push_instr(5'd15, 5'd1, 5'd1, 5'd0);
    do_issue(20, '{5'd15, 5'd1, 5'd1, 5'd0, 5'd5, 32'd10, 32'd10, 5'h1F, 5'h1F}, 3);

    // asynchronous reset while issuing
    set_reg(5'd12, 32'd5, 5'd6);
    push_instr(5'd16, 5'd12, 5'd1, 5'd3);
    wait_valid(lat);
    chk("pre_rst_tag1", out_tag_1, 5'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_rs_valid, 1'b0);
    chk("arst_tag1", out_tag_1, 5'h1F);
    chk("arst_val1", out_val_1, 32'd0);
    chk("arst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_rd", out_rd_en, 1'b0);
    chk("post_rst_valid", out_rs_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
